// File: rtl/pwm_multi_ch.sv
// N-channel PWM with shared prescaler/period counter and shadowed period/duty.
// Optional centre-aligned counting is enabled by defining PWM_CENTER_ALIGN_EN.
module pwm_multi_ch #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 12,
    parameter int DEF_PERIOD = 4095,
    parameter int ADDR_W     = 5
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);

    logic              en_q;
    logic [NUM_CH-1:0] pol_q;
    logic [CNT_W-1:0]  per_sh_q, per_act_q, pre_q;
    logic [CNT_W-1:0]  duty_sh_q  [NUM_CH];
    logic [CNT_W-1:0]  duty_act_q [NUM_CH];
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              tick_q;
    logic [31:0]       rd_q, rd_d;

    logic              wr_ctrl, wr_per, wr_pre;
    logic [NUM_CH-1:0] wr_duty;
    logic              shadow_wr, pre_tick, boundary;
    logic [NUM_CH-1:0] raw;
    logic              unused_wr;

    assign unused_wr = ^wr_data;

    assign wr_ctrl = wr_en && (addr == ADDR_W'(0));
    assign wr_per  = wr_en && (addr == ADDR_W'(1));
    assign wr_pre  = wr_en && (addr == ADDR_W'(2));

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            wr_duty[i] = wr_en && (addr == ADDR_W'(i + 4));
    end

    assign shadow_wr = wr_per || (|wr_duty);
    assign pre_tick  = en_q && (pre_cnt_q >= pre_q);
    assign pre_cnt_d = !en_q ? '0 :
                       pre_tick ? '0 : pre_cnt_q + CNT_W'(1);

`ifdef PWM_CENTER_ALIGN_EN
    logic ca_q;
    logic dir_q, dir_d;

    // Valley (end of down phase) is the only load point in centre mode.
    always_comb begin
        if (ca_q)
            boundary = pre_tick && (dir_q ? (cnt_q <= CNT_W'(1))
                       : (per_act_q <= CNT_W'(1) && cnt_q >= per_act_q));
        else
            boundary = pre_tick && (cnt_q >= per_act_q);
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!en_q) begin
            cnt_d = '0;
            dir_d = 1'b0;
        end else if (pre_tick) begin
            if (boundary) begin
                cnt_d = '0;
                dir_d = 1'b0;
            end else if (ca_q && !dir_q && cnt_q >= per_act_q) begin
                cnt_d = per_act_q - CNT_W'(1);
                dir_d = 1'b1;
            end else if (ca_q && dir_q) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ca_q  <= 1'b0;
            dir_q <= 1'b0;
        end else begin
            if (wr_ctrl) ca_q <= wr_data[1];
            dir_q <= dir_d;
        end
    end
`else
    always_comb begin
        boundary = pre_tick && (cnt_q >= per_act_q);
        cnt_d    = cnt_q;
        if (!en_q)         cnt_d = '0;
        else if (pre_tick) cnt_d = boundary ? '0 : cnt_q + CNT_W'(1);
    end
`endif

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            raw[i] = cnt_q < duty_act_q[i];
    end

    assign pwm_d  = en_q ? (raw ^ pol_q) : pol_q;
    assign pend_d = en_q && (shadow_wr || (pend_q && !boundary));

    always_comb begin
        rd_d = '0;
        if (addr == ADDR_W'(0)) begin
            rd_d[0]          = en_q;
            rd_d[NUM_CH+7:8] = pol_q;
`ifdef PWM_CENTER_ALIGN_EN
            rd_d[1]          = ca_q;
`endif
        end
        if (addr == ADDR_W'(1)) rd_d[CNT_W-1:0] = per_sh_q;
        if (addr == ADDR_W'(2)) rd_d[CNT_W-1:0] = pre_q;
        if (addr == ADDR_W'(3)) begin
            rd_d[0] = en_q;
            rd_d[1] = pend_q;
`ifdef PWM_CENTER_ALIGN_EN
            rd_d[2] = dir_q;
`endif
        end
        for (int i = 0; i < NUM_CH; i++)
            if (addr == ADDR_W'(i + 4)) rd_d[CNT_W-1:0] = duty_sh_q[i];
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            en_q      <= 1'b0;
            pol_q     <= '0;
            per_sh_q  <= DEF_P;
            per_act_q <= DEF_P;
            pre_q     <= '0;
            pend_q    <= 1'b0;
            pre_cnt_q <= '0;
            cnt_q     <= '0;
            pwm_q     <= '0;
            tick_q    <= 1'b0;
            rd_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            if (wr_ctrl) begin
                en_q  <= wr_data[0];
                pol_q <= wr_data[NUM_CH+7:8];
            end
            if (wr_pre) pre_q <= wr_data[CNT_W-1:0];
            if (wr_per) per_sh_q <= wr_data[CNT_W-1:0];
            for (int i = 0; i < NUM_CH; i++)
                if (wr_duty[i]) duty_sh_q[i] <= wr_data[CNT_W-1:0];
            // Actives take the pre-write shadow, so a same-cycle write waits.
            if (!en_q || boundary) begin
                per_act_q <= per_sh_q;
                for (int i = 0; i < NUM_CH; i++)
                    duty_act_q[i] <= duty_sh_q[i];
            end
            pend_q    <= pend_d;
            pre_cnt_q <= pre_cnt_d;
            cnt_q     <= cnt_d;
            pwm_q     <= pwm_d;
            tick_q    <= boundary;
            if (rd_en) rd_q <= rd_d;
        end
    end

    assign rd_data     = rd_q;
    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;

endmodule
